partition_error_meter: RTL and testbench
========================================

// Module: partition_error_meter
// PURPOSE
//   Exhaustive on-chip evaluator for one extracted logic partition (e.g. a 7-in/4-out adder slice).
//   Sweeps every input vector into an exact and an approximate partition instance,
//   consumes both output words and accumulates error metrics: mismatch count, Hamming sum,
//   absolute-error sum and maximum absolute error.
//   Sits directly downstream of the partition outputs and also drives their shared input bus.
// PARAMETERS
//   NI      7   partition input width; the sweep covers 2**NI vectors
//   NO      4   partition output width; outputs are treated as unsigned
// PORTS
//   clk          in   1        rising-edge clock
//   rst_n        in   1        asynchronous, active-low reset
//   start        in   1        sampled only in IDLE; 1 = begin sweep
//   pi_o         out  NI       vector driven to both partition instances (combinational DUTs)
//   po_exact_i   in   NO       exact partition output for pi_o
//   po_approx_i  in   NO       approximate partition output for pi_o
//   busy         out  1        high in RUN and DRAIN
//   done         out  1        one-cycle pulse; results are final
//   err_count    out  NI+1     number of vectors where exact != approx
//   ham_sum      out  NI+$clog2(NO+1)   sum of popcount(exact ^ approx)
//   abs_sum      out  NI+NO    sum of |exact - approx|
//   max_abs      out  NO       maximum |exact - approx|
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, pi_o = 0, accumulators cleared.
//   FSM: IDLE -(start)-> RUN -(vec == all ones)-> DRAIN (1 cycle) -> DONE (1 cycle) -> IDLE.
//   On IDLE->RUN: clear accumulators and the vector counter.
//   RUN: pi_o = counter; counter increments +1 per cycle; no wrap occurs inside RUN.
//   pi_o = 0 in IDLE, DRAIN and DONE.
//   Pipeline:
//   - S1 registers xor/popcount/abs-diff of the po_* pair for the current pi_o, with a valid bit.
//   - S2 adds S1 into the accumulators on the next edge.
//   Abs diff: (NO+1)-bit signed subtract, then magnitude.
//   max_abs updates when the new diff > max_abs (strict).
//   Timing (start sampled in cycle 0):
//   - pi_o = 0..2**NI-1 in cycles 1..2**NI.
//   - Last accumulation at the end of cycle 2**NI+1.
//   - done = 1 in cycle 2**NI+2 (cycle 130 for NI=7).
//   Result outputs hold their final values from done until the next accepted start, then clear.
//   start while busy or in DONE is ignored.
//   start held high continuously gives back-to-back sweeps with period 2**NI+3.
//   Accumulator widths are sized for the worst case; no saturation logic is present.
//   rst_n asserted mid-sweep aborts immediately with all reset values.
//   The first start after rst_n release yields complete, correct results.
// STRUCTURE
//   partition_eval_pkg: state enum {IDLE, RUN, DRAIN, DONE} and width functions
//   (ham_w(NI,NO), abs_w(NI,NO)).
//   Sub-module partition_err_diff: registered S1 stage (xor, popcount, abs diff, valid).
//   Top level holds the FSM, vector counter and S2 accumulators.
// TESTING
//   1. approx = exact = pi[3:0] model, start -> all metrics 0, done in cycle 130, busy 1..129.
//   2. approx = exact with bit0 forced 0 -> err_count=64, ham_sum=64, abs_sum=64, max_abs=1.
//   3. exact = 4'h0, approx = 4'hF -> err_count=128, ham_sum=512, abs_sum=1920, max_abs=15.
//   4. rst_n low at cycle 50 -> outputs 0 and busy 0 asynchronously;
//      restart with the test-2 model -> exact test-2 results.
//   5. start pulsed at cycles 20 and 130 of a sweep -> ignored; start held high ->
//      done every 131 cycles, results identical each sweep.
//   6. NI=3, NO=2 instance, approx = ~exact -> err_count=8, ham_sum=16, done in cycle 10.

Source files
------------

// File: rtl/partition_eval_pkg.sv
// Shared state encoding and accumulator width helpers for the partition error meter.
package partition_eval_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // Bits needed to hold a popcount of an NO-bit word.
  function automatic int pop_w(input int no);
    return $clog2(no + 1);
  endfunction

  // Worst case: every one of 2**ni vectors differs in all no bits.
  function automatic int ham_w(input int ni, input int no);
    return ni + $clog2(no + 1);
  endfunction

  // Worst case: 2**ni vectors each at the full-scale difference 2**no-1.
  function automatic int abs_w(input int ni, input int no);
    return ni + no;
  endfunction

endpackage

// File: rtl/partition_err_diff.sv
// S1 stage: registers mismatch, Hamming distance and absolute difference of one output pair.
module partition_err_diff
  import partition_eval_pkg::*;
#(
  parameter int NO = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_vld,
  input  logic [NO-1:0]        exact,
  input  logic [NO-1:0]        approx,
  output logic                 vld,
  output logic                 mism,
  output logic [pop_w(NO)-1:0] pop,
  output logic [NO-1:0]        absd
);

  localparam int PW = pop_w(NO);

  logic [NO-1:0] x;
  logic [PW-1:0] pc;
  logic [NO:0]   diff;
  logic [NO:0]   neg;
  logic [NO-1:0] mag;

  always_comb begin
    x  = exact ^ approx;
    pc = '0;
    for (int i = 0; i < NO; i++) pc = pc + PW'(x[i]);
    // One extra bit keeps the sign of exact - approx for unsigned operands.
    diff = {1'b0, exact} - {1'b0, approx};
    neg  = -diff;
    mag  = diff[NO] ? neg[NO-1:0] : diff[NO-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      mism <= 1'b0;
      pop  <= '0;
      absd <= '0;
    end else begin
      vld  <= in_vld;
      mism <= |x;
      pop  <= pc;
      absd <= mag;
    end
  end

endmodule

// File: rtl/partition_error_meter.sv
// Exhaustive sweep of a combinational partition pair with pipelined error-metric accumulation.
module partition_error_meter
  import partition_eval_pkg::*;
#(
  parameter int NI = 7,
  parameter int NO = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic [NI-1:0]           pi_o,
  input  logic [NO-1:0]           po_exact_i,
  input  logic [NO-1:0]           po_approx_i,
  output logic                    busy,
  output logic                    done,
  output logic [NI:0]             err_count,
  output logic [ham_w(NI,NO)-1:0] ham_sum,
  output logic [abs_w(NI,NO)-1:0] abs_sum,
  output logic [NO-1:0]           max_abs
);

  localparam int ERR_W = NI + 1;
  localparam int HAM_W = ham_w(NI, NO);
  localparam int ABS_W = abs_w(NI, NO);
  localparam int PW    = pop_w(NO);

  state_t        state;
  logic [NI-1:0] vec;
  logic          accept;
  logic [1:0]    vld_pipe;
  logic          s1_mism;
  logic [PW-1:0] s1_pop;
  logic [NO-1:0] s1_abs;

  assign accept      = (state == IDLE) && start;
  // vec is held at zero outside RUN, so it can drive the partition bus directly.
  assign pi_o        = vec;
  assign vld_pipe[0] = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      vec   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            vec   <= '0;
          end
        end
        RUN: begin
          if (&vec) begin
            state <= DRAIN;
            vec   <= '0;
          end else begin
            vec <= vec + 1'b1;
          end
        end
        DRAIN: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  partition_err_diff #(.NO(NO)) u_s1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_vld (vld_pipe[0]),
    .exact  (po_exact_i),
    .approx (po_approx_i),
    .vld    (vld_pipe[1]),
    .mism   (s1_mism),
    .pop    (s1_pop),
    .absd   (s1_abs)
  );

  // S2: results stay frozen from done until the next accepted start clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
      ham_sum   <= '0;
      abs_sum   <= '0;
      max_abs   <= '0;
    end else if (accept) begin
      err_count <= '0;
      ham_sum   <= '0;
      abs_sum   <= '0;
      max_abs   <= '0;
    end else if (vld_pipe[1]) begin
      err_count <= err_count + ERR_W'(s1_mism);
      ham_sum   <= ham_sum + HAM_W'(s1_pop);
      abs_sum   <= abs_sum + ABS_W'(s1_abs);
      if (s1_abs > max_abs) max_abs <= s1_abs;
    end
  end

endmodule

// File: tb/tb_partition_error_meter.sv
// Randomized self-checking bench for partition_error_meter against a sweep-level metric model.
module tb_partition_error_meter;

  typedef struct {
    int err;
    int ham;
    int abs_s;
    int mx;
  } met_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  pi;
  logic [3:0]  po_e, po_a;
  logic        busy, done;
  logic [7:0]  err_count;
  logic [9:0]  ham_sum;
  logic [10:0] abs_sum;
  logic [3:0]  max_abs;

  logic        start2 = 1'b0;
  logic [2:0]  pi2;
  logic [1:0]  pe2, pa2;
  logic        busy2, done2;
  logic [3:0]  err2;
  logic [4:0]  ham2;
  logic [4:0]  abs2;
  logic [1:0]  max2;

  int          checks = 0;
  int          errors = 0;
  int          mode = 0;
  logic [3:0]  ex_lut [128];
  logic [3:0]  ap_lut [128];
  logic [1:0]  lut2 [8];
  string       mname [4] = '{"err_count", "ham_sum", "abs_sum", "max_abs"};
  logic [31:0] got [4];
  logic [31:0] want [4];

  always #5 clk = ~clk;

  partition_error_meter #(.NI(7), .NO(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pi_o(pi),
    .po_exact_i(po_e), .po_approx_i(po_a), .busy(busy), .done(done),
    .err_count(err_count), .ham_sum(ham_sum), .abs_sum(abs_sum), .max_abs(max_abs)
  );

  partition_error_meter #(.NI(3), .NO(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .pi_o(pi2),
    .po_exact_i(pe2), .po_approx_i(pa2), .busy(busy2), .done(done2),
    .err_count(err2), .ham_sum(ham2), .abs_sum(abs2), .max_abs(max2)
  );

  // Partition models driven onto the DUT's inputs.
  function automatic logic [3:0] ex_f(input int m, input logic [6:0] v);
    case (m)
      0, 1:    return v[3:0];
      2:       return 4'h0;
      default: return ex_lut[v];
    endcase
  endfunction

  function automatic logic [3:0] ap_f(input int m, input logic [6:0] v);
    case (m)
      0:       return v[3:0];
      1:       return {v[3:1], 1'b0};
      2:       return 4'hF;
      default: return ap_lut[v];
    endcase
  endfunction

  always_comb begin
    po_e = ex_f(mode, pi);
    po_a = ap_f(mode, pi);
    pe2  = lut2[pi2];
    pa2  = ~pe2;
  end

  function automatic met_t model7(input int m);
    met_t r = '{0, 0, 0, 0};
    for (int v = 0; v < 128; v++) begin
      int e = int'(ex_f(m, 7'(v)));
      int a = int'(ap_f(m, 7'(v)));
      int d = (e > a) ? e - a : a - e;
      if (e != a) r.err++;
      r.ham   += $countones(4'(e) ^ 4'(a));
      r.abs_s += d;
      if (d > r.mx) r.mx = d;
    end
    return r;
  endfunction

  function automatic met_t model3();
    met_t r = '{0, 0, 0, 0};
    for (int v = 0; v < 8; v++) begin
      logic [1:0] eb = lut2[v];
      logic [1:0] ab = ~eb;
      int e = int'(eb);
      int a = int'(ab);
      int d = (e > a) ? e - a : a - e;
      if (e != a) r.err++;
      r.ham   += $countones(eb ^ ab);
      r.abs_s += d;
      if (d > r.mx) r.mx = d;
    end
    return r;
  endfunction

  // Starts one sweep (start high for cycle 0) and follows it to done.
  task automatic sweep(input int pa, input int pb, output int dc,
                       output bit bad_busy, output bit bad_pi);
    dc = -1; bad_busy = 1'b0; bad_pi = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 1; cyc < 400; cyc++) begin
      if (busy !== (cyc <= 129)) bad_busy = 1'b1;
      if (pi !== ((cyc >= 1 && cyc <= 128) ? 7'(cyc - 1) : 7'd0)) bad_pi = 1'b1;
      start = (cyc == pa) || (cyc == pb);
      if (done === 1'b1) begin dc = cyc; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, pi, err_count, ham_sum, abs_sum, max_abs} !== '0) begin
      errors++;
      $display("FAIL reset_main: got busy=%b done=%b pi=%0d err=%0d ham=%0d abs=%0d max=%0d exp all 0",
               busy, done, pi, err_count, ham_sum, abs_sum, max_abs);
    end
    checks++;
    if ({busy2, done2, pi2, err2, ham2, abs2, max2} !== '0) begin
      errors++;
      $display("FAIL reset_small: got busy=%b done=%b err=%0d ham=%0d exp all 0", busy2, done2, err2, ham2);
    end
  endtask

  task automatic test_sweep(input int m, input string tag);
    met_t r; int dc; bit bb, bp;
    mode = m;
    r = model7(m);
    sweep(-1, -1, dc, bb, bp);
    checks++;
    if (dc !== 130) begin errors++; $display("FAIL %s done_cycle: got %0d exp 130", tag, dc); end
    checks++;
    if (bb) begin errors++; $display("FAIL %s busy_window: got mismatch exp busy only in cycles 1..129", tag); end
    checks++;
    if (bp) begin errors++; $display("FAIL %s pi_sequence: got mismatch exp pi=cycle-1 in 1..128 else 0", tag); end
    got  = '{32'(err_count), 32'(ham_sum), 32'(abs_sum), 32'(max_abs)};
    want = '{r.err, r.ham, r.abs_s, r.mx};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[k] !== want[k]) begin
        errors++;
        $display("FAIL %s %s: got %0d exp %0d", tag, mname[k], got[k], want[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < 128; i++) begin
        ex_lut[i] = 4'($urandom_range(0, 15));
        ap_lut[i] = ($urandom_range(0, 3) == 0) ? ex_lut[i] : 4'($urandom_range(0, 15));
      end
      test_sweep(3, $sformatf("random%0d", it));
    end
  endtask

  task automatic test_abort();
    mode = 1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (49) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, pi, err_count, ham_sum, abs_sum, max_abs} !== '0) begin
      errors++;
      $display("FAIL abort_async: got busy=%b pi=%0d err=%0d ham=%0d abs=%0d max=%0d exp all 0",
               busy, pi, err_count, ham_sum, abs_sum, max_abs);
    end
    @(negedge clk); rst_n = 1'b1;
    test_sweep(1, "after_abort");
  endtask

  task automatic test_ignore_start();
    met_t r; int dc; bit bb, bp;
    mode = 2;
    r = model7(2);
    sweep(20, 130, dc, bb, bp);
    checks++;
    if (dc !== 130) begin errors++; $display("FAIL ignore done_cycle: got %0d exp 130", dc); end
    checks++;
    if (bb) begin errors++; $display("FAIL ignore busy_window: got mismatch exp busy only in cycles 1..129"); end
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (busy !== 1'b0 || pi !== 7'd0) begin
        errors++;
        $display("FAIL ignore_done_start busy: got busy=%b pi=%0d exp busy=0 pi=0", busy, pi);
      end
      got  = '{32'(err_count), 32'(ham_sum), 32'(abs_sum), 32'(max_abs)};
      want = '{r.err, r.ham, r.abs_s, r.mx};
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (got[k] !== want[k]) begin
          errors++;
          $display("FAIL ignore_hold %s: got %0d exp %0d", mname[k], got[k], want[k]);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    met_t r; int n; int dcs [3];
    mode = 1;
    r = model7(1);
    n = 0;
    dcs = '{-1, -1, -1};
    @(negedge clk); start = 1'b1;
    for (int cyc = 1; cyc < 500 && n < 3; cyc++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dcs[n] = cyc;
        n++;
        got  = '{32'(err_count), 32'(ham_sum), 32'(abs_sum), 32'(max_abs)};
        want = '{r.err, r.ham, r.abs_s, r.mx};
        for (int k = 0; k < 4; k++) begin
          checks++;
          if (got[k] !== want[k]) begin
            errors++;
            $display("FAIL b2b sweep%0d %s: got %0d exp %0d", n, mname[k], got[k], want[k]);
          end
        end
      end
    end
    start = 1'b0;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (dcs[s] !== 130 + 131 * s) begin
        errors++;
        $display("FAIL b2b done_cycle%0d: got %0d exp %0d", s, dcs[s], 130 + 131 * s);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_small();
    met_t r; int dc; bit bb;
    for (int i = 0; i < 8; i++) lut2[i] = 2'($urandom_range(0, 3));
    r = model3();
    dc = -1; bb = 1'b0;
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    for (int cyc = 1; cyc < 50; cyc++) begin
      if (busy2 !== (cyc <= 9)) bb = 1'b1;
      if (done2 === 1'b1) begin dc = cyc; break; end
      @(negedge clk);
    end
    checks++;
    if (dc !== 10) begin errors++; $display("FAIL small done_cycle: got %0d exp 10", dc); end
    checks++;
    if (bb) begin errors++; $display("FAIL small busy_window: got mismatch exp busy only in cycles 1..9"); end
    got  = '{32'(err2), 32'(ham2), 32'(abs2), 32'(max2)};
    want = '{8, 16, r.abs_s, r.mx};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[k] !== want[k]) begin
        errors++;
        $display("FAIL small %s: got %0d exp %0d", mname[k], got[k], want[k]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin ex_lut[i] = 4'h0; ap_lut[i] = 4'h0; end
    for (int i = 0; i < 8; i++) lut2[i] = 2'b00;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_sweep(0, "equal");
    test_sweep(1, "bit0");
    test_sweep(2, "full");
    test_random();
    test_abort();
    test_ignore_start();
    test_back_to_back();
    test_small();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish exp finish within 500000 time units");
    $fatal(1, "timeout");
  end

endmodule
